// File: rtl/wb_slave_router.sv
// Registered Wishbone router: decodes each management-port request to the user or debug slave,
// runs one transaction at a time, and terminates unacknowledged transactions with a watchdog.
module wb_slave_router #(
  parameter logic [28:0] DEBUG_ADR    = 29'h601FFFF,
  parameter int          TIMEOUT      = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        user_cyc_o,
  output logic        user_stb_o,
  input  logic        user_ack_i,
  input  logic [31:0] user_dat_i,
  output logic        dbg_cyc_o,
  output logic        dbg_stb_o,
  input  logic        dbg_ack_i,
  input  logic [31:0] dbg_dat_i,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [7:0]  to_count_o,
  output logic [31:0] to_adr_o,
  output logic        to_irq_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_tgt_dbg;
  logic [7:0]  r_wd;
  logic        r_ack;
  logic        r_irq;
  logic [31:0] r_dat;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [7:0]  r_to_count;
  logic [31:0] r_to_adr;

  logic        w_active;
  logic        w_accept;
  logic        w_tgt_ack;
  logic        w_abort;
  logic        w_ack_evt;
  logic        w_expire;

  assign w_active  = (r_state == ACTIVE);
  assign w_accept  = (r_state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign w_tgt_ack = r_tgt_dbg ? dbg_ack_i : user_ack_i;
  // A master abort outranks both a real ack and the watchdog: the master is no longer listening.
  assign w_abort   = w_active && !wbs_cyc_i;
  assign w_ack_evt = w_active && !w_abort && w_tgt_ack;
  assign w_expire  = w_active && !w_abort && !w_tgt_ack && (r_wd == WD_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = ACTIVE;
      ACTIVE: begin
        if (w_abort)                     w_state_next = IDLE;
        else if (w_ack_evt || w_expire)  w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_tgt_dbg  <= 1'b0;
      r_wd       <= 8'd0;
      r_ack      <= 1'b0;
      r_irq      <= 1'b0;
      r_dat      <= 32'd0;
      r_we       <= 1'b0;
      r_sel      <= 4'd0;
      r_adr      <= 32'd0;
      r_wdat     <= 32'd0;
      r_to_count <= 8'd0;
      r_to_adr   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack_evt || w_expire;
      r_irq   <= w_expire;
      if (w_accept) begin
        r_we      <= wbs_we_i;
        r_sel     <= wbs_sel_i;
        r_adr     <= wbs_adr_i;
        r_wdat    <= wbs_dat_i;
        r_tgt_dbg <= (wbs_adr_i[31:3] == DEBUG_ADR);
        r_wd      <= 8'd0;
      end else if (w_active && !w_abort && !w_tgt_ack && !w_expire) begin
        r_wd <= r_wd + 8'd1;
      end
      if (w_ack_evt) begin
        r_dat <= r_tgt_dbg ? dbg_dat_i : user_dat_i;
      end
      if (w_expire) begin
        r_dat    <= TIMEOUT_DATA;
        r_to_adr <= r_adr;
        if (r_to_count != 8'hFF) r_to_count <= r_to_count + 8'd1;
      end
    end
  end

  assign user_cyc_o = w_active && !r_tgt_dbg;
  assign user_stb_o = w_active && !r_tgt_dbg;
  assign dbg_cyc_o  = w_active && r_tgt_dbg;
  assign dbg_stb_o  = w_active && r_tgt_dbg;
  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign s_we_o     = r_we;
  assign s_sel_o    = r_sel;
  assign s_adr_o    = r_adr;
  assign s_dat_o    = r_wdat;
  assign to_count_o = r_to_count;
  assign to_adr_o   = r_to_adr;
  assign to_irq_o   = r_irq;

endmodule

// File: tb/tb_wb_slave_router.sv
// Self-checking bench for wb_slave_router: directed vector table, randomized transactions
// against a spec-level latency/data model, timeout saturation and asynchronous reset.
module tb_wb_slave_router;

  localparam int          TIMEOUT = 16;
  localparam logic [28:0] DBG_ADR = 29'h601FFFF;
  localparam logic [31:0] TO_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        u_cyc, u_stb, u_ack = 1'b0;
  logic [31:0] u_dat = 32'd0;
  logic        d_cyc, d_stb, d_ack = 1'b0;
  logic [31:0] d_dat = 32'd0;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic [7:0]  to_count;
  logic [31:0] to_adr;
  logic        to_irq;

  always #5 clk = ~clk;

  wb_slave_router #(.DEBUG_ADR(DBG_ADR), .TIMEOUT(TIMEOUT), .TIMEOUT_DATA(TO_DATA)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
    .user_cyc_o(u_cyc), .user_stb_o(u_stb), .user_ack_i(u_ack), .user_dat_i(u_dat),
    .dbg_cyc_o(d_cyc), .dbg_stb_o(d_stb), .dbg_ack_i(d_ack), .dbg_dat_i(d_dat),
    .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dat),
    .to_count_o(to_count), .to_adr_o(to_adr), .to_irq_o(to_irq)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          ack_at;    // strobe cycle in which the target acks (0 = never)
    int          abort_at;  // strobe cycle in which the master drops cyc (0 = never)
    logic        exp_dbg;
    int          exp_lat;   // launch edge to ack edge, 0 = no ack expected
    logic [31:0] exp_data;
    logic        exp_to;
    int          exp_stb;   // strobe-high cycles
  } txn_t;

  int n_pass = 0;
  int n_total = 0;
  int irq_total = 0;
  logic [7:0]  m_count = 8'd0;
  logic [31:0] m_adr = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: outcome derived directly from the routing/watchdog rules.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    r.exp_dbg = (t.adr[31:3] == DBG_ADR);
    r.exp_to = 1'b0;
    r.exp_data = 32'd0;
    if (t.abort_at > 0 && (t.ack_at == 0 || t.ack_at > t.abort_at)) begin
      r.exp_lat = 0;
      r.exp_stb = t.abort_at;
    end else if (t.ack_at >= 1 && t.ack_at <= TIMEOUT) begin
      r.exp_lat = t.ack_at + 1;
      r.exp_data = t.rdat;
      r.exp_stb = t.ack_at;
    end else begin
      r.exp_lat = TIMEOUT + 1;
      r.exp_data = TO_DATA;
      r.exp_stb = TIMEOUT;
      r.exp_to = 1'b1;
    end
    return r;
  endfunction

  task automatic run_txn(input txn_t t);
    int strobes = 0, other = 0, irqs = 0, lat = 0, acks = 0;
    logic [31:0] got = 32'd0;
    logic tgt_stb, oth_stb;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = t.we; sel = t.sel; adr = t.adr; wdat = t.wdat;
    u_dat = t.exp_dbg ? ~t.rdat : t.rdat;
    d_dat = t.exp_dbg ? t.rdat : ~t.rdat;
    // The non-selected slave acks constantly; the router must ignore it.
    u_ack = t.exp_dbg;
    d_ack = !t.exp_dbg;
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      @(posedge clk); #1;
      tgt_stb = t.exp_dbg ? (d_cyc & d_stb) : (u_cyc & u_stb);
      oth_stb = t.exp_dbg ? (u_cyc | u_stb) : (d_cyc | d_stb);
      if (to_irq) irqs++;
      if (oth_stb) other++;
      if (k == 1) begin
        chk("s_adr", s_adr, t.adr);
        chk("s_we_sel_dat", {s_we, s_sel, s_dat}, {t.we, t.sel, t.wdat});
      end
      if (ack_o) begin
        acks++;
        if (lat == 0) begin lat = k; got = dat_o; end
        cyc = 1'b0; stb = 1'b0;
      end
      if (tgt_stb) strobes++;
      if (t.exp_dbg) d_ack = tgt_stb && (strobes == t.ack_at);
      else           u_ack = tgt_stb && (strobes == t.ack_at);
      if (tgt_stb && strobes == t.abort_at) begin cyc = 1'b0; stb = 1'b0; end
      if (lat != 0 && k == lat + 1) break;
    end
    u_ack = 1'b0; d_ack = 1'b0; cyc = 1'b0; stb = 1'b0;
    irq_total += irqs;
    if (t.exp_to) begin
      if (m_count != 8'hFF) m_count = m_count + 8'd1;
      m_adr = t.adr;
    end
    $display("txn adr=%h we=%0d ack_at=%0d abort_at=%0d lat=%0d data=%h strobes=%0d irq=%0d cnt=%0d",
             t.adr, t.we, t.ack_at, t.abort_at, lat, got, strobes, irqs, to_count);
    chk("ack_latency", lat, t.exp_lat);
    if (t.exp_lat != 0) chk("ack_data", got, t.exp_data);
    chk("ack_count", acks, (t.exp_lat != 0) ? 1 : 0);
    chk("strobe_cycles", strobes, t.exp_stb);
    chk("other_strobe", other, 0);
    chk("irq_pulses", irqs, t.exp_to ? 1 : 0);
    chk("to_count", to_count, m_count);
    chk("to_adr", to_adr, m_adr);
  endtask

  txn_t vec[6];
  txn_t t;
  int sat_irq0;

  initial begin
    //        adr           we    sel    wdat          rdat          ack abort dbg lat data          to  stb
    vec[0] = '{32'h300FFFF8, 1'b0, 4'hF, 32'h0,        32'h12345678, 2,  0,    1,  3,  32'h12345678, 0,  2};
    vec[1] = '{32'h30000000, 1'b1, 4'h3, 32'hA5A5A5A5, 32'h0,        0,  0,    0,  17, 32'hDEADBEEF, 1,  16};
    vec[2] = '{32'h300FFFF4, 1'b0, 4'hF, 32'h0,        32'h0BADF00D, 1,  0,    0,  2,  32'h0BADF00D, 0,  1};
    vec[3] = '{32'h300FFFFC, 1'b1, 4'h8, 32'h11223344, 32'hCAFEBABE, 1,  0,    1,  2,  32'hCAFEBABE, 0,  1};
    vec[4] = '{32'h30000010, 1'b0, 4'hF, 32'h0,        32'h55AA55AA, 16, 0,    0,  17, 32'h55AA55AA, 0,  16};
    vec[5] = '{32'h30000020, 1'b1, 4'h1, 32'h99999999, 32'h0,        0,  3,    0,  0,  32'h0,        0,  3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {31'd0, ack_o | u_stb | u_cyc | d_stb | d_cyc | to_irq}, 32'd0);
    chk("reset_dat_cnt", dat_o | {24'd0, to_count} | to_adr | s_adr, 32'd0);
    rst = 1'b0;

    foreach (vec[i]) run_txn(vec[i]);

    for (int n = 0; n < 40; n++) begin
      t.adr = ($urandom_range(0, 2) == 0) ? {DBG_ADR, 3'($urandom_range(0, 7))} : $urandom;
      t.we = 1'($urandom);
      t.sel = 4'($urandom);
      t.wdat = $urandom;
      t.rdat = $urandom;
      t.ack_at = $urandom_range(0, TIMEOUT + 2);
      t.abort_at = 0;
      if ($urandom_range(0, 3) == 0) begin
        t.abort_at = $urandom_range(1, TIMEOUT - 1);
        if (t.ack_at == t.abort_at) t.ack_at = 0;
      end
      run_txn(model(t));
    end

    sat_irq0 = irq_total;
    for (int n = 0; n < 260; n++) begin
      t = '{32'h30000100 + 32'(n * 4), 1'b0, 4'hF, 32'h0, 32'h0, 0, 0, 1'b0, 0, 32'h0, 1'b0, 0};
      run_txn(model(t));
    end
    chk("sat_count", to_count, 8'd255);
    chk("sat_irqs", irq_total - sat_irq0, 260);

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h30000040; we = 1'b1; wdat = 32'h77777777;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_strobe", {31'd0, u_stb}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_ctl", {31'd0, ack_o | u_stb | u_cyc | d_stb | d_cyc | to_irq}, 32'd0);
    chk("async_reset_data", dat_o | {24'd0, to_count} | to_adr | s_adr | s_dat | {31'd0, s_we}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    m_count = 8'd0; m_adr = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(vec[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_slave_router.md
# wb_slave_router

Registered Wishbone slave router for the user project area. It sits between the management SoC Wishbone port (`wbs_*`) and two downstream slaves: the user project slave and the debug register block. The router decodes each request to exactly one slave and sequences a single outstanding transaction. A bus watchdog terminates any transaction the selected slave never acknowledges, so an absent or hung user slave cannot stall the management core.

## Interface
Parameters:
- `DEBUG_ADR`, 29'h601FFFF: value of `adr[31:3]` that selects the debug slave (byte range 0x300FFFF8–0x300FFFFF).
- `TIMEOUT`, 16: maximum number of ACTIVE cycles before the watchdog fires. Legal range 2..255.
- `TIMEOUT_DATA`, 32'hDEADBEEF: read data returned on a watchdog termination.

Ports (clock and reset first):
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset; asynchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  master request.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  registered ack to master.
- `wbs_dat_o`  out  32  registered read data to master.
- `user_cyc_o`, `user_stb_o`  out  1 each  user slave strobe.
- `user_ack_i`  in  1  user slave ack.
- `user_dat_i`  in  32  user slave read data.
- `dbg_cyc_o`, `dbg_stb_o`  out  1 each  debug slave strobe.
- `dbg_ack_i`  in  1  debug slave ack.
- `dbg_dat_i`  in  32  debug slave read data.
- `s_we_o`, `s_sel_o`, `s_adr_o`, `s_dat_o`  out  1/4/32/32  shared slave request fields, registered at acceptance.
- `to_count_o`  out  8  saturating count of watchdog terminations.
- `to_adr_o`  out  32  address of the most recent watchdog termination.
- `to_irq_o`  out  1  one-cycle pulse on each watchdog termination.

## Operation
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - When `wbs_cyc_i & wbs_stb_i` is sampled, latch we/sel/adr/dat into `s_*_o`.
  - Latch target: DEBUG if `wbs_adr_i[31:3] == DEBUG_ADR`, else USER.
  - Clear the watchdog counter and go to ACTIVE.
- ACTIVE:
  - Assert `cyc_o`/`stb_o` of the latched target only. The other slave's strobes stay 0.
  - Ack input from the non-selected slave is ignored.
  - Target ack sampled high: register `wbs_dat_o` from the target's data (reads and writes alike), set `wbs_ack_o`, go to DONE.
  - Watchdog counter increments on each ACTIVE cycle without target ack.
  - If the counter reaches `TIMEOUT-1` without ack, terminate:
    - `wbs_ack_o`=1, `wbs_dat_o`=`TIMEOUT_DATA`;
    - `to_irq_o`=1 for that cycle;
    - `to_adr_o`=latched address;
    - `to_count_o` increments, saturating at 255;
    - go to DONE.
  - Target ack and watchdog expiry in the same cycle: the real ack wins and no timeout is recorded.
  - `wbs_cyc_i` sampled low (master abort): drop slave strobes, go to IDLE, no ack, no timeout record.
- DONE:
  - `wbs_ack_o` is high for exactly this one cycle. Slave strobes are 0.
  - Return to IDLE unconditionally.
  - A request still asserted in the following IDLE cycle is treated as a new transaction.
- `wbs_dat_o` holds its last value outside DONE.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE;
  - all strobes, `wbs_ack_o`, and `to_irq_o` = 0;
  - `wbs_dat_o`, `s_*_o`, `to_adr_o`, and `to_count_o` = 0.
- Request sampled at edge N → slave strobe high from edge N+1.
- Slave ack high in the cycle after edge N+k (k ≥ 1) → `wbs_ack_o` high from edge N+k+1 for one cycle.
  - Minimum master latency, with a combinational slave ack: request to ack at edge N+2.
- Watchdog: the slave strobe is held for exactly `TIMEOUT` cycles. `wbs_ack_o`=1 with `TIMEOUT_DATA` at edge N+TIMEOUT+1.
- Back-to-back transactions: at most one per 3 cycles (IDLE, ACTIVE, DONE).
- Slave acks arriving in IDLE or DONE are ignored.
- `to_irq_o` and the terminating `wbs_ack_o` assert on the same edge.

## Test plan
- Debug read: read 0x300FFFF8 with the debug slave acking 1 cycle after strobe and data 0x12345678 → only `dbg_stb_o` asserted; `wbs_ack_o` for one cycle with data 0x12345678, 3 cycles after request.
- User write with `user_ack_i` tied 0 and TIMEOUT=16: write to 0x30000000 → `user_stb_o` high 16 cycles; ack with 0xDEADBEEF at request+17; `to_irq_o` pulse; `to_count_o`=1; `to_adr_o`=0x30000000.
- Boundary decode: address 0x300FFFF4 routes to the user slave; 0x300FFFFC routes to the debug slave. The non-selected slave's strobes stay 0 throughout.
- Simultaneous ack and expiry: user ack arrives on the 16th ACTIVE cycle → its data is returned; `to_count_o` is unchanged; no irq.
- Master abort: drop `wbs_cyc_i` on the 3rd ACTIVE cycle → strobes are 0 on the next edge; no ack; counters unchanged. Then assert reset mid-ACTIVE → all outputs 0 immediately.
- Saturation: 260 consecutive timeouts → `to_count_o` stays at 255, and 260 `to_irq_o` pulses are observed.
